intf_fifo_bridge: RTL and testbench
===================================

INTF_FIFO_BRIDGE -- requirements
Module: intf_fifo_bridge

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, data width per transfer (>=1).
REQ-002 SHALL provide parameter DEPTH, default 4, buffer entries (power of two, >=2).
REQ-003 SHALL provide clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide m_valid  input  1  master side: word offered.
REQ-006 SHALL provide m_data  input  WIDTH  master side: offered word.
REQ-007 SHALL provide m_ready  output  1  master side: bridge accepts word.
REQ-008 SHALL provide s_valid  output  1  slave side: word available.
REQ-009 SHALL provide s_data  output  WIDTH  slave side: head word.
REQ-010 SHALL provide s_ready  input  1  slave side: slave takes word.
REQ-011 SHALL provide level  output  $clog2(DEPTH+1)  number of stored words.
REQ-012 SHALL provide par_err  output  1  sticky parity-error flag.

Function
REQ-013 SHALL push m_data when m_valid && m_ready at a rising clk edge.
REQ-014 SHALL pop the head word when s_valid && s_ready at a rising clk edge.
REQ-015 SHALL drive m_ready = (level != DEPTH), registered-state-derived, independent of m_valid.
REQ-016 SHALL drive s_valid = (level != 0), independent of s_ready.
REQ-017 SHALL present the head word on s_data combinationally from storage; pushed word visible on s_data one cycle after push when buffer was empty (latency 1).
REQ-018 SHALL preserve strict FIFO order; no word lost, duplicated or reordered.
REQ-019 SHALL update level: +1 push only, -1 pop only, unchanged on simultaneous push+pop or neither.
REQ-020 SHALL accept simultaneous push and pop when 0 < level < DEPTH; full: push blocked, pop allowed; empty: pop impossible, push allowed.
REQ-021 SHALL use write/read pointers of $clog2(DEPTH) bits wrapping from DEPTH-1 to 0 without gap.
REQ-022 SHALL sustain one transfer per cycle per side indefinitely when both sides are always ready/valid.
REQ-023 SHALL leave s_data value unspecified (don't-care) while s_valid is 0; bench SHALL not check it.
REQ-024 SHALL ignore m_data/m_valid changes when m_ready is 0.

Reset
REQ-025 SHALL, on rst high, asynchronously clear pointers, level to 0, par_err to 0; m_ready=1 (once rst low: 1 immediately), s_valid=0.
REQ-026 SHALL discard all buffered words on reset, including assertion mid-transfer; no transfer occurs on any edge with rst high.
REQ-027 SHALL not require storage array reset; stale contents never appear with s_valid=1.

Configuration
REQ-028 SHALL honour macro INTF_FIFO_BRIDGE_PARITY_EN.
REQ-029 With INTF_FIFO_BRIDGE_PARITY_EN defined: each entry stores an extra even-parity bit (XOR of m_data) computed at push; on each pop the stored bit is rechecked against stored data and a mismatch sets par_err, held until reset.
REQ-030 Without INTF_FIFO_BRIDGE_PARITY_EN: no parity storage or logic; par_err tied to 0.

Verification
REQ-031 Reset then push 0x0A5, 0x15A, 0xFFF with s_ready=0 -> level=3, s_data=0x0A5, s_valid=1, m_ready=1.
REQ-032 DEPTH=4: push 5 words with s_ready=0 -> only 4 accepted, m_ready=0 after 4th, level=4; then s_ready=1 -> words out in order, m_ready rises the cycle after first pop.
REQ-033 level=2, m_valid=1 and s_ready=1 for 100 cycles with incrementing data -> level stays 2, 100 words out in order, pointers wrap 25 times without error.
REQ-034 level=3, assert rst for one cycle between edges -> level=0, s_valid=0, m_ready=1 immediately; next pushed word 0x123 appears as head.
REQ-035 Parity build: force one stored bit flip via backdoor, pop that word -> par_err=1 next cycle, remains 1 through later clean pops until rst; non-parity build -> par_err=0 always.

Source files
------------

// File: rtl/intf_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : intf_fifo_bridge
//  Description : Valid/ready FIFO bridge between a master and a slave port.
//                DEPTH-entry circular buffer with registered pointers and level.
//                The head word is read combinationally from storage.
//                Optional feature macro INTF_FIFO_BRIDGE_PARITY_EN:
//                  - adds one even-parity bit per entry, computed at push
//                  - rechecks that bit on every pop
//                  - drives a sticky par_err flag
//  Revision    : 1.0 - initial release
// ============================================================================
module intf_fifo_bridge #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_valid,
    input  logic [WIDTH-1:0]           m_data,
    output logic                       m_ready,
    output logic                       s_valid,
    output logic [WIDTH-1:0]           s_data,
    input  logic                       s_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       par_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH+1);
`ifdef INTF_FIFO_BRIDGE_PARITY_EN
    localparam int c_ENTRY_W = WIDTH + 1;
`else
    localparam int c_ENTRY_W = WIDTH;
`endif
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);

    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_LVL_W-1:0]   level_q, level_d;
    logic [c_ENTRY_W-1:0] mem_q [DEPTH];

    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_rd_entry;

    // Handshake flags come only from registered level; no transfer while in reset.
    assign m_ready    = (level_q != c_LVL_FULL);
    assign s_valid    = (level_q != '0);
    assign level      = level_q;
    assign w_push     = m_valid && m_ready && !rst;
    assign w_pop      = s_valid && s_ready && !rst;
    assign w_rd_entry = mem_q[rd_ptr_q];
    assign s_data     = w_rd_entry[WIDTH-1:0];

`ifdef INTF_FIFO_BRIDGE_PARITY_EN
    // Parity bit sits above the data so that XOR over a good entry is zero.
    assign w_wr_entry = {^m_data, m_data};
`else
    assign w_wr_entry = m_data;
`endif

    // Next-state for pointers and level; power-of-two depth wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_LVL_ONE;
            2'b01:   level_d = level_q - c_LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is plain RAM-style, without reset; level gating hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_wr_entry;
        end
    end

`ifdef INTF_FIFO_BRIDGE_PARITY_EN
    logic par_err_q, par_err_d;
    logic w_par_bad;

    assign w_par_bad = ^w_rd_entry;
    assign par_err   = par_err_q;

    // A parity miss on any popped entry latches the error until reset.
    always_comb begin
        par_err_d = par_err_q;
        if (w_pop && w_par_bad) begin
            par_err_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_intf_fifo_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intf_fifo_bridge
//  Description : Scoreboard bench for intf_fifo_bridge. The reference model is
//                a queue of accepted words. Build with
//                INTF_FIFO_BRIDGE_PARITY_EN to exercise the parity path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intf_fifo_bridge;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_ready;
    logic [LVL_W-1:0] level;
    logic             par_err;

    int               total = 0;
    int               bad   = 0;
    int               npop  = 0;
    logic [WIDTH-1:0] exp_q [$];
    bit               exp_par = 1'b0;

    intf_fifo_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .level   (level),
        .par_err (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare flags and level with the model, and score every pop.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("level", 32'(level), 32'(exp_q.size()));
            chk("s_valid", 32'(s_valid), 32'(exp_q.size() != 0));
            chk("m_ready", 32'(m_ready), 32'(exp_q.size() != DEPTH));
            chk("par_err", 32'(par_err), 32'(exp_par));
            if (s_valid && s_ready) begin
                npop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty: got pop with s_data %0h expected no pop", s_data);
                end else begin
                    chk("s_data", 32'(s_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Drive one cycle of stimulus; record the push that the next edge will perform.
    task automatic cycle(input bit mv, input logic [WIDTH-1:0] d, input bit sr);
        @(posedge clk);
        #1;
        m_valid = mv;
        m_data  = d;
        s_ready = sr;
        @(negedge clk);
        #1;
        if (!rst && m_valid && m_ready) exp_q.push_back(m_data);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic do_reset();
        @(posedge clk);
        #2;
        m_valid = 1'b0;
        s_ready = 1'b0;
        rst     = 1'b1;
        exp_q.delete();
        exp_par = 1'b0;
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m_ready", 32'(m_ready), 32'd1);
        chk("rst_par_err", 32'(par_err), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst     = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        s_ready = 1'b0;
        do_reset();

        // Three pushes with a stalled slave.
        cycle(1'b1, 12'h0A5, 1'b0);
        cycle(1'b1, 12'h15A, 1'b0);
        cycle(1'b1, 12'hFFF, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("three_level", 32'(level), 32'd3);
        chk("three_head", 32'(s_data), 32'h0A5);
        chk("three_s_valid", 32'(s_valid), 32'd1);
        chk("three_m_ready", 32'(m_ready), 32'd1);
        drain();

        // Overfill: five offers, only DEPTH accepted.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 12'h100 + 12'(i), 1'b0);
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_m_ready", 32'(m_ready), 32'd0);
        chk("full_model", 32'(exp_q.size()), 32'(DEPTH));
        drain();

        // Steady streaming at level 2.
        do_reset();
        cycle(1'b1, 12'h000, 1'b0);
        cycle(1'b1, 12'h001, 1'b0);
        p0 = npop;
        for (int i = 0; i < 100; i++) cycle(1'b1, 12'(i + 2), 1'b1);
        chk("stream_pops", 32'(npop - p0), 32'd100);
        cycle(1'b0, '0, 1'b0);
        chk("stream_level", 32'(level), 32'd2);
        drain();

        // Reset mid-stream at level 3, then push a fresh word.
        cycle(1'b1, 12'h0AA, 1'b0);
        cycle(1'b1, 12'h0BB, 1'b0);
        cycle(1'b1, 12'h0CC, 1'b0);
        do_reset();
        cycle(1'b1, 12'h123, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("post_rst_head", 32'(s_data), 32'h123);
        chk("post_rst_level", 32'(level), 32'd1);
        drain();

        // Randomized traffic in phases with different valid/ready densities.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                cycle($urandom_range(0, 3) > ph[1:0] ? 1'b1 : 1'b0,
                      WIDTH'($urandom),
                      $urandom_range(0, 3) >= ph[1:0] ? 1'b1 : 1'b0);
            end
        end
        drain();

`ifdef INTF_FIFO_BRIDGE_PARITY_EN
        // Corrupt the stored parity bit of the head entry, then pop it.
        begin
            int idx;
            do_reset();
            cycle(1'b1, 12'h3C1, 1'b0);
            cycle(1'b1, 12'h0F0, 1'b0);
            cycle(1'b1, 12'h777, 1'b0);
            cycle(1'b0, '0, 1'b0);
            idx = int'(dut.rd_ptr_q);
            dut.mem_q[idx][WIDTH] = ~dut.mem_q[idx][WIDTH];
            cycle(1'b0, '0, 1'b1);
            exp_par = 1'b1;
            cycle(1'b0, '0, 1'b1);
            cycle(1'b0, '0, 1'b1);
            cycle(1'b0, '0, 1'b0);
            chk("par_sticky", 32'(par_err), 32'd1);
            do_reset();
            cycle(1'b0, '0, 1'b0);
            chk("par_cleared", 32'(par_err), 32'd0);
        end
`else
        chk("par_tied", 32'(par_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
